// File: rtl/intr_arb.sv
// intr_arb: interrupt arbiter between the iopage device mux and the CPU core.
//
// Picks the highest requesting level from interrupt_ipl[7:1] and qualifies it
// against the CPU priority in psw[7:5]. It presents one request with a latched
// vector and level, and returns a one-cycle one-hot ack_ipl after the CPU
// accepts. It then waits for the device to drop its request. If the request
// does not drop within DROP_TIMEOUT cycles, it raises a sticky stuck_err.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   interrupt_ipl  per-level requests (bit n = level n, bit 0 ignored)
//   vector_in      device vector, valid while its request is asserted
//   psw            processor status word, [7:5] = current CPU priority
//   cpu_int_ack    CPU accepts the presented interrupt (sampled only in REQ)
//   err_clr        clears stuck_err
//   cpu_int_req    qualified interrupt request to the CPU
//   cpu_int_vector latched vector, stable while cpu_int_req=1
//   cpu_int_ipl    latched level, stable while cpu_int_req=1
//   ack_ipl        one-hot, one-cycle acknowledge back to iopage
//   stuck_err      sticky: acknowledged source failed to drop in time
//   arb_state      FSM state for debug (IDLE=0, REQ=1, ACK=2, DROP=3)
//
// Build option INTR_SYNC_EN: when defined, interrupt_ipl and vector_in pass
// through a two-flop synchronizer before arbitration. The request latency is
// then 3 cycles.

module intr_arb #(
  parameter int unsigned DROP_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  interrupt_ipl,
  input  logic [7:0]  vector_in,
  input  logic [15:0] psw,
  input  logic        cpu_int_ack,
  input  logic        err_clr,
  output logic        cpu_int_req,
  output logic [7:0]  cpu_int_vector,
  output logic [2:0]  cpu_int_ipl,
  output logic [7:0]  ack_ipl,
  output logic        stuck_err,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [7:0]         ipl_s, vec_s;
  logic [2:0]         pri;
  logic [2:0]         win;
  logic               win_ok;
  logic               src_held;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               req_nx;
  logic [7:0]         vec_nx;
  logic [2:0]         ipl_nx;
  logic [7:0]         ack_nx;
  logic               err_nx;
  logic               set_err;
  logic               unused_bits;

`ifdef INTR_SYNC_EN
  logic [7:0] ipl_m, vec_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ipl_m <= '0;
      vec_m <= '0;
      ipl_s <= '0;
      vec_s <= '0;
    end else begin
      ipl_m <= interrupt_ipl;
      vec_m <= vector_in;
      ipl_s <= ipl_m;
      vec_s <= vec_m;
    end
  end
`else
  assign ipl_s = interrupt_ipl;
  assign vec_s = vector_in;
`endif

  assign pri         = psw[7:5];
  assign unused_bits = ^{psw[15:8], psw[4:0], ipl_s[0]};

  // Highest set level in [7:1]. The ascending scan lets the last hit win.
  always_comb begin
    win = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (ipl_s[i]) win = 3'(i);
    end
  end

  // A winner of 0 (no request) can never exceed any priority.
  assign win_ok   = (win > pri);
  assign src_held = ipl_s[cpu_int_ipl];

  always_comb begin
    state_nx = state;
    req_nx   = cpu_int_req;
    vec_nx   = cpu_int_vector;
    ipl_nx   = cpu_int_ipl;
    ack_nx   = '0;
    cnt_nx   = cnt;
    set_err  = 1'b0;

    case (state)
      IDLE: begin
        if (win_ok) begin
          state_nx = REQ;
          req_nx   = 1'b1;
          ipl_nx   = win;
          vec_nx   = vec_s;
        end
      end
      REQ: begin
        if (cpu_int_ack) begin
          state_nx = ACK;
          req_nx   = 1'b0;
          ack_nx   = 8'b1 << cpu_int_ipl;
        end else if (!src_held || (cpu_int_ipl <= pri)) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
        end else if (win_ok && (win > cpu_int_ipl)) begin
          ipl_nx = win;
          vec_nx = vec_s;
        end
      end
      ACK: begin
        cnt_nx   = '0;
        state_nx = DROP;
      end
      DROP: begin
        cnt_nx = cnt + CNT_W'(1);
        if (!src_held) begin
          state_nx = IDLE;
        end else if (cnt == CNT_W'(DROP_TIMEOUT - 1)) begin
          set_err  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A set in the same cycle as a clear wins.
    err_nx = set_err | (stuck_err & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cpu_int_req    <= 1'b0;
      cpu_int_vector <= '0;
      cpu_int_ipl    <= '0;
      ack_ipl        <= '0;
      stuck_err      <= 1'b0;
      cnt            <= '0;
    end else begin
      state          <= state_nx;
      cpu_int_req    <= req_nx;
      cpu_int_vector <= vec_nx;
      cpu_int_ipl    <= ipl_nx;
      ack_ipl        <= ack_nx;
      stuck_err      <= err_nx;
      cnt            <= cnt_nx;
    end
  end

  assign arb_state = state;

endmodule

// File: doc/intr_arb.md
Name: intr_arb

Overview:
- Interrupt arbiter sitting between the iopage device mux and the CPU core.
- Consumes the per-level request vector `interrupt_ipl` and the device vector.
- Compares the winning level against the current PSW priority and presents a single qualified request plus latched vector/level to the CPU.
- Closes the handshake by returning a one-cycle one-hot `ack_ipl` pulse to the device mux, then waits for the device to drop its request.

Parameters:
- DROP_TIMEOUT, 64: max cycles to wait in DROP for the acknowledged level to deassert before flagging `stuck_err`.
- CNT_W, 7: drop counter width; must hold DROP_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- interrupt_ipl  in  8  per-level request from iopage; bit n = level n; bit 0 ignored
- vector_in  in  8  device vector; valid while its request is asserted
- psw  in  16  processor status word; bits [7:5] are the current CPU priority
- cpu_int_ack  in  1  CPU accepts the presented interrupt (instruction boundary); sampled only in REQ
- err_clr  in  1  clears sticky `stuck_err`
- cpu_int_req  out  1  qualified interrupt request to CPU
- cpu_int_vector  out  8  latched vector; stable while `cpu_int_req`=1
- cpu_int_ipl  out  3  latched level; stable while `cpu_int_req`=1
- ack_ipl  out  8  one-hot, one-cycle acknowledge back to iopage
- stuck_err  out  1  sticky: acknowledged source failed to drop within DROP_TIMEOUT
- arb_state  out  2  current FSM state, for debug

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - `cpu_int_req`=0, `cpu_int_vector`=0, `cpu_int_ipl`=0, `ack_ipl`=0, `stuck_err`=0, drop counter=0.
- Winner: highest set bit of `interrupt_ipl[7:1]`, called L. Eligible when L > `psw[7:5]` (unsigned). Equal priority is not eligible.
- State encoding: IDLE=0, REQ=1, ACK=2, DROP=3. All outputs registered.
- IDLE:
  - If eligible in cycle n: latch L into `cpu_int_ipl` and `vector_in` into `cpu_int_vector`, enter REQ, assert `cpu_int_req` in cycle n+1.
- REQ (`cpu_int_req`=1):
  - If `cpu_int_ack`=1: go to ACK; drop `cpu_int_req` next cycle. Ack has priority over every other condition in the same cycle.
  - Else, if `interrupt_ipl[cpu_int_ipl]`=0, or `cpu_int_ipl` <= `psw[7:5]`: withdraw. Go to IDLE with `cpu_int_req`=0 next cycle; latched values hold.
  - Else, if a winner L' > `cpu_int_ipl` is eligible: preempt. Relatch L' and its vector; stay in REQ with `cpu_int_req` held high.
- ACK:
  - `ack_ipl`[`cpu_int_ipl`]=1 for exactly this one cycle; all other bits 0.
  - Clear the drop counter and go to DROP.
- DROP:
  - Increment the counter each cycle.
  - If `interrupt_ipl[cpu_int_ipl]`=0: go to IDLE.
  - Else, if counter == DROP_TIMEOUT-1: set `stuck_err` and go to IDLE.
  - A new request is not arbitrated until the next cycle in IDLE.
- Latencies:
  - Eligible request → `cpu_int_req`: 1 cycle.
  - `cpu_int_ack` → `ack_ipl` pulse: 1 cycle.
  - Minimum request-to-request turnaround: 4 cycles.
- `stuck_err`:
  - Sticky; cleared only by `err_clr` or reset.
  - If a set and `err_clr` occur in the same cycle, set wins.
- Boundary cases:
  - `interrupt_ipl`=0x01 (level 0 only): never eligible.
  - `psw[7:5]`=7: nothing is eligible.
  - `cpu_int_ack` outside REQ: ignored.
  - Reset asserted mid-handshake: immediately returns to IDLE. No `ack_ipl` is emitted.

Optional Feature:
- Macro: INTR_SYNC_EN.
- Defined:
  - `interrupt_ipl` and `vector_in` pass through a two-flop synchronizer (reset to 0) before arbitration.
  - Request latency becomes 3 cycles.
  - The DROP release check uses the synchronized level.
- Undefined: inputs are used directly. All latencies are as stated above.

Test Plan:
- Reset, then `interrupt_ipl`=0x40, `vector_in`=0x40, psw[7:5]=0 → `cpu_int_req`=1 next cycle, `cpu_int_ipl`=6, `cpu_int_vector`=0x40.
- In REQ pulse `cpu_int_ack`, source drops 2 cycles later → `ack_ipl`=0x40 for exactly one cycle, `cpu_int_req`=0, return to IDLE, `stuck_err`=0.
- `interrupt_ipl`=0x10, psw[7:5]=4 → `cpu_int_req` stays 0. Lower psw[7:5] to 3 → request 1 cycle later with `cpu_int_ipl`=4.
- In REQ at level 4 (vector 0x30), raise `interrupt_ipl` to 0x50 with vector 0x40 → `cpu_int_ipl`=6, `cpu_int_vector`=0x40 next cycle, `cpu_int_req` never drops.
- In REQ, clear the source bit and assert `cpu_int_ack` in the same cycle → ACK wins, `ack_ipl` pulse issued.
- After ack, hold `interrupt_ipl`=0x20 for 100 cycles with DROP_TIMEOUT=64 → `stuck_err`=1 after 64 cycles in DROP. Re-request follows in IDLE. `err_clr` → `stuck_err`=0.
